// File: rtl/fir_pkg.sv
// Fixed-point word-length defaults and quantization helpers for the FIR output path.
// Shared by the decimator and by the FIR output quantizer.
package fir_pkg;

   localparam int FIR_IN_INTE_WL  = 4;
   localparam int FIR_IN_FRAC_WL  = 8;
   localparam int FIR_OUT_INTE_WL = 4;
   localparam int FIR_OUT_FRAC_WL = 8;
   localparam int FIR_DECIM       = 4;
   localparam int FIR_FIFO_DEPTH  = 4;

   typedef struct packed {
      logic signed [63:0] q;
      logic               sat;
   } rs_t;

   function automatic int fir_log2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Arithmetic is carried at 64 bits, so the half-LSB rounding add cannot wrap.
   function automatic rs_t round_sat(input logic signed [63:0] sum,
                                     input int                 s,
                                     input int                 out_wl);
      rs_t                r;
      logic signed [63:0] q;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      if (s > 0) q = (sum + (64'sd1 <<< (s - 1))) >>> s;
      else       q = sum <<< (-s);
      hi    = (64'sd1 <<< (out_wl - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (out_wl - 1));
      r.sat = (q > hi) || (q < lo);
      r.q   = (q > hi) ? hi : ((q < lo) ? lo : q);
      return r;
   endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so the consumer
// sees a stable registered output; storage is a plain array written on push.
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [fir_log2(DEPTH):0]   o_count
);

   localparam int AW = fir_log2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_do_push;
   logic             w_do_pop;
   logic [AW-1:0]    w_rd_next;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is still taken when the head leaves on the same edge.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign w_rd_next = r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= w_rd_next;

         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // Next head comes from memory unless the only stored entry is leaving,
         // in which case a simultaneous push bypasses straight into the head.
         if (w_do_pop) begin
            if (r_count != (AW+1)'(1))  r_head <= r_mem[w_rd_next];
            else if (w_do_push)         r_head <= i_din;
         end else if (w_do_push && o_empty) begin
            r_head <= i_din;
         end
      end
   end

   assign o_head  = r_head;
   assign o_count = r_count;

endmodule

// File: rtl/fir_decim_dump.sv
// Integrate-and-dump decimator behind the FIR: averages DECIM valid samples,
// re-quantizes with round-half-up and saturation, and queues results for a valid/ready consumer.
module fir_decim_dump
   import fir_pkg::*;
#(
   parameter int IN_INTE_WL  = FIR_IN_INTE_WL,
   parameter int IN_FRAC_WL  = FIR_IN_FRAC_WL,
   parameter int OUT_INTE_WL = FIR_OUT_INTE_WL,
   parameter int OUT_FRAC_WL = FIR_OUT_FRAC_WL,
   parameter int DECIM       = FIR_DECIM,
   parameter int FIFO_DEPTH  = FIR_FIFO_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL] data_in,
   input  logic                                   in_valid,
   output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic                                   sat_event,
   output logic                                   ovf_sticky
);

   localparam int IN_W  = IN_INTE_WL + IN_FRAC_WL;
   localparam int OUT_W = OUT_INTE_WL + OUT_FRAC_WL;
   localparam int LOG2D = fir_log2(DECIM);
   localparam int ACC_W = IN_W + LOG2D;
   localparam int SHIFT = LOG2D + IN_FRAC_WL - OUT_FRAC_WL;
   localparam int CNT_W = fir_log2(FIFO_DEPTH) + 1;

   logic signed [ACC_W-1:0] r_acc;
   logic [LOG2D-1:0]        r_phase;
   logic                    r_sat;
   logic                    r_ovf;

   logic signed [ACC_W-1:0] w_din_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic                    w_last;
   logic                    w_dump;
   logic                    w_pop;
   logic                    w_drop;
   logic                    w_full;
   logic                    w_empty;
   logic [CNT_W-1:0]        w_unused_count;
   logic [OUT_W-1:0]        w_q;
   logic [OUT_W-1:0]        w_head;
   rs_t                     w_rs;

   assign w_din_ext = ACC_W'(data_in);
   assign w_sum     = r_acc + w_din_ext;
   // DECIM is a power of two, so the last phase is all ones and the counter wraps by itself.
   assign w_last    = &r_phase;
   assign w_dump    = in_valid && w_last;
   assign w_pop     = out_valid && out_ready;
   assign w_drop    = w_dump && w_full && !w_pop;

   always_comb begin
      w_rs = round_sat(64'(w_sum), SHIFT, OUT_W);
   end

   assign w_q = w_rs.q[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc   <= '0;
         r_phase <= '0;
         r_sat   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_sat <= w_dump && w_rs.sat;
         if (in_valid) begin
            r_phase <= r_phase + 1'b1;
            r_acc   <= (r_phase == '0) ? w_din_ext : w_sum;
         end
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   fir_out_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_dump),
      .i_din   (w_q),
      .i_pop   (out_ready),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_unused_count)
   );

   assign data_out   = w_head;
   assign out_valid  = !w_empty;
   assign sat_event  = r_sat;
   assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_fir_decim_dump.sv
// Scoreboard bench for fir_decim_dump: three parameterizations driven by directed
// groups; monitors pop expected results whenever an output is accepted.
module tb_fir_decim_dump;

   logic clk;
   int   n_checks;
   int   n_errors;

   logic               rst_a, vin_a, rdy_a, vo_a, sat_a, ovf_a;
   logic signed [11:0] din_a;
   logic signed [11:0] dout_a;
   logic               rst_b, vin_b, rdy_b, vo_b, sat_b, ovf_b;
   logic signed [11:0] din_b;
   logic signed [9:0]  dout_b;
   logic               rst_c, vin_c, rdy_c, vo_c, sat_c, ovf_c;
   logic signed [11:0] din_c;
   logic signed [9:0]  dout_c;

   int q_a[$];
   int q_b[$];
   int q_c[$];

   fir_decim_dump dut_a (
      .clk(clk), .rst(rst_a), .data_in(din_a), .in_valid(vin_a),
      .data_out(dout_a), .out_valid(vo_a), .out_ready(rdy_a),
      .sat_event(sat_a), .ovf_sticky(ovf_a)
   );

   fir_decim_dump #(.OUT_FRAC_WL(6)) dut_b (
      .clk(clk), .rst(rst_b), .data_in(din_b), .in_valid(vin_b),
      .data_out(dout_b), .out_valid(vo_b), .out_ready(rdy_b),
      .sat_event(sat_b), .ovf_sticky(ovf_b)
   );

   fir_decim_dump #(.OUT_INTE_WL(2)) dut_c (
      .clk(clk), .rst(rst_c), .data_in(din_c), .in_valid(vin_c),
      .data_out(dout_c), .out_valid(vo_c), .out_ready(rdy_c),
      .sat_event(sat_c), .ovf_sticky(ovf_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [31:0] act, input int req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin : mon_a
      if (vo_a === 1'b1 && rdy_a === 1'b1) begin
         if (q_a.size() == 0) chk("a_unexpected_output", 32'(dout_a), -99999);
         else                 chk("a_data_out", 32'(dout_a), q_a.pop_front());
      end
   end

   always @(negedge clk) begin : mon_b
      if (vo_b === 1'b1 && rdy_b === 1'b1) begin
         if (q_b.size() == 0) chk("b_unexpected_output", 32'(dout_b), -99999);
         else                 chk("b_data_out", 32'(dout_b), q_b.pop_front());
      end
   end

   always @(negedge clk) begin : mon_c
      if (vo_c === 1'b1 && rdy_c === 1'b1) begin
         if (q_c.size() == 0) chk("c_unexpected_output", 32'(dout_c), -99999);
         else                 chk("c_data_out", 32'(dout_c), q_c.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input int v, input logic vld);
      case (which)
         0:       begin din_a = 12'(v); vin_a = vld; end
         1:       begin din_b = 12'(v); vin_b = vld; end
         default: begin din_c = 12'(v); vin_c = vld; end
      endcase
   endtask

   // Gap cycles carry a junk value with in_valid low; it must not reach the sum.
   task automatic feed(input int which, input int v, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         drive(which, v, 1'b1);
         step();
         if (gap) begin
            drive(which, 1000, 1'b0);
            step();
         end
      end
      drive(which, 0, 1'b0);
   endtask

   task automatic drain_a(input string name);
      int i;
      for (i = 0; i < 40; i++) begin
         if (q_a.size() == 0) break;
         step();
      end
      if (i == 40) chk({name, "_drain_timeout"}, q_a.size(), 0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      rdy_a = 1'b0; rdy_b = 1'b1; rdy_c = 1'b1;
      drive(0, 0, 1'b0); drive(1, 0, 1'b0); drive(2, 0, 1'b0);
      step();
      step();
      chk("rst_data_out", 32'(dout_a), 0);
      chk("rst_out_valid", 32'(vo_a), 0);
      chk("rst_sat_event", 32'(sat_a), 0);
      chk("rst_ovf_sticky", 32'(ovf_a), 0);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Four samples of 1.0 average to 1.0; valid rises one cycle after the 4th.
      feed(0, 256, 3, 1'b0);
      chk("a_valid_before_dump", 32'(vo_a), 0);
      feed(0, 256, 1, 1'b0);
      chk("a_valid_latency", 32'(vo_a), 1);
      chk("a_head_early", 32'(dout_a), 256);
      chk("a_sat_none", 32'(sat_a), 0);
      q_a.push_back(256);
      rdy_a = 1'b1;
      step();
      chk("a_valid_after_pop", 32'(vo_a), 0);
      step();
      chk("a_empty_hold", 32'(dout_a), 256);

      // Reset mid-group drops both the buffered result and the partial sum.
      rdy_a = 1'b0;
      feed(0, 512, 4, 1'b0);
      chk("a_buffered_head", 32'(dout_a), 512);
      feed(0, 256, 2, 1'b0);
      rst_a = 1'b0;
      step();
      chk("a_midrst_data_out", 32'(dout_a), 0);
      chk("a_midrst_out_valid", 32'(vo_a), 0);
      chk("a_midrst_sat", 32'(sat_a), 0);
      chk("a_midrst_ovf", 32'(ovf_a), 0);
      rst_a = 1'b1;
      rdy_a = 1'b1;
      q_a.push_back(256);
      feed(0, 256, 4, 1'b0);
      q_a.push_back(256);
      feed(0, 256, 4, 1'b1);
      drain_a("a_gap");
      step();
      chk("a_gap_hold", 32'(dout_a), 256);

      // Five groups into a depth-4 FIFO with no consumer: the 5th is dropped.
      rdy_a = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         feed(0, k, 4, 1'b0);
         if (k <= 4) q_a.push_back(k);
      end
      chk("a_ovf_set", 32'(ovf_a), 1);
      chk("a_full_valid", 32'(vo_a), 1);
      chk("a_full_head", 32'(dout_a), 1);
      rdy_a = 1'b1;
      drain_a("a_ovf");
      chk("a_ovf_valid_falls", 32'(vo_a), 0);
      chk("a_ovf_still_set", 32'(ovf_a), 1);

      // Full FIFO with a pop on the dump edge accepts the new result.
      rst_a = 1'b0;
      step();
      rst_a = 1'b1;
      rdy_a = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         feed(0, k, 4, 1'b0);
         q_a.push_back(k);
      end
      feed(0, 5, 3, 1'b0);
      drive(0, 5, 1'b1);
      rdy_a = 1'b1;
      step();
      drive(0, 0, 1'b0);
      q_a.push_back(5);
      chk("a_fullpop_ovf_clear", 32'(ovf_a), 0);
      chk("a_fullpop_head", 32'(dout_a), 2);
      drain_a("a_fullpop");
      chk("a_fullpop_valid_falls", 32'(vo_a), 0);
      chk("a_fullpop_ovf_end", 32'(ovf_a), 0);

      // OUT_FRAC_WL=6: shift of 4 with round half up.
      feed(1, 2, 4, 1'b0);
      q_b.push_back(1);
      feed(1, -2, 4, 1'b0);
      q_b.push_back(0);
      chk("b_sat_none", 32'(sat_b), 0);

      // OUT_INTE_WL=2: 10-bit output clips at 511 / -512.
      feed(2, 768, 4, 1'b0);
      q_c.push_back(511);
      chk("c_sat_pos_pulse", 32'(sat_c), 1);
      step();
      chk("c_sat_pos_clear", 32'(sat_c), 0);
      feed(2, -2048, 4, 1'b0);
      q_c.push_back(-512);
      chk("c_sat_neg_pulse", 32'(sat_c), 1);
      step();
      chk("c_sat_neg_clear", 32'(sat_c), 0);
      feed(2, 256, 4, 1'b0);
      q_c.push_back(256);
      chk("c_sat_inrange", 32'(sat_c), 0);

      repeat (6) step();
      chk("a_queue_empty", q_a.size(), 0);
      chk("b_queue_empty", q_b.size(), 0);
      chk("c_queue_empty", q_c.size(), 0);
      chk("b_ovf_clear", 32'(ovf_b), 0);
      chk("c_ovf_clear", 32'(ovf_c), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
